// File: rtl/switch_debounce_pkg.sv
// Shared constants for the switch-conditioning stage: bit positions of the DIP-switch
// fields and the default debounce window.
package switch_debounce_pkg;

    localparam int SW_WIDTH            = 5;
    localparam int SW_STEP_LSB         = 0;
    localparam int SW_STEP_MSB         = 3;
    localparam int SW_UPDN_BIT         = 4;
    localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;

    typedef logic [SW_WIDTH-1:0] sw_t;

    typedef struct packed {
        logic                             up_down;
        logic [SW_STEP_MSB:SW_STEP_LSB]   step;
    } sw_fields_t;

    // Count up, step 0 after reset.
    localparam sw_t SW_RESET_VAL = sw_t'(1) << SW_UPDN_BIT;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch-level bundle between the raw DIP switches and the conditioned outputs.
// master drives the raw levels; slave is the debouncer.
interface switch_debounce_if #(
    parameter int WIDTH = switch_debounce_pkg::SW_WIDTH
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             any_change;

    modport master (
        output sw_in,
        input  sw_out, sw_rise, sw_fall, any_change
    );

    modport slave (
        input  sw_in,
        output sw_out, sw_rise, sw_fall, any_change
    );
endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchroniser, stability counter, registered level and edge pulses.
// Latency 2+STABLE_CYCLES clocks from a clean input change to sw_o; no backpressure.
module debounce_bit #(
    parameter int   STABLE_CYCLES = 1_000_000,
    parameter int   CNT_W         = 20,
    parameter logic RST_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Any cycle where the synchronised level agrees with the output restarts the window.
        if (s2_q != out_q) begin
            if (cnt_q == TERM_CNT) begin
                out_d  = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= RST_BIT;
            s2_q   <= RST_BIT;
            cnt_q  <= '0;
            out_q  <= RST_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_o   = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Debounces the DIP-switch levels feeding the step counter; one independent debouncer per bit.
// Latency 2+STABLE_CYCLES clocks; any_change is the same-cycle OR of the registered pulses.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int               WIDTH         = SW_WIDTH,
    parameter int               STABLE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int               CNT_W         = 20,
    parameter logic [WIDTH-1:0] RESET_VAL     = WIDTH'(SW_RESET_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    switch_debounce_if.slave  sw
);

    logic [WIDTH-1:0] out_w, rise_w, fall_w;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .RST_BIT       (RESET_VAL[b])
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .sw_i   (sw.sw_in[b]),
            .sw_o   (out_w[b]),
            .rise_o (rise_w[b]),
            .fall_o (fall_w[b])
        );
    end

    assign sw.sw_out     = out_w;
    assign sw.sw_rise    = rise_w;
    assign sw.sw_fall    = fall_w;
    assign sw.any_change = |(rise_w | fall_w);

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce (STABLE_CYCLES=4): a window-based reference model
// is checked every cycle, plus hand-computed expectations at the interesting points.
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    localparam int  S  = 4;
    localparam sw_t RV = 5'h10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_debounce_if #(.WIDTH(SW_WIDTH)) sw_if ();

    switch_debounce #(
        .WIDTH         (SW_WIDTH),
        .STABLE_CYCLES (S),
        .CNT_W         (3),
        .RESET_VAL     (RV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit flips when the last S synchronised samples all disagree with
    // the current output and at least S edges have passed since its last update or reset.
    sw_t samp [0:4095];
    int  edge_n = 0;
    int  last_upd [SW_WIDTH];
    bit  started = 0;
    sw_t m_out, m_rise, m_fall;

    always @(posedge clk) begin
        if (rst) begin
            samp[edge_n] = RV;
            if (edge_n > 0) samp[edge_n-1] = RV;
            m_out = RV; m_rise = '0; m_fall = '0;
            for (int b = 0; b < SW_WIDTH; b++) last_upd[b] = edge_n;
            started = 1;
        end else begin
            sw_t nxt;
            samp[edge_n] = sw_if.sw_in;
            nxt = m_out; m_rise = '0; m_fall = '0;
            for (int b = 0; b < SW_WIDTH; b++) begin
                bit stable;
                stable = started && (edge_n - last_upd[b] >= S);
                for (int j = 0; j < S; j++) begin
                    int idx;
                    idx = edge_n - 2 - j;
                    if (idx < 0 || samp[idx][b] == m_out[b]) stable = 0;
                end
                if (stable) begin
                    nxt[b] = ~m_out[b];
                    m_rise[b] = ~m_out[b];
                    m_fall[b] = m_out[b];
                    last_upd[b] = edge_n;
                end
            end
            m_out = nxt;
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model sw_out",     8'(sw_if.sw_out),     8'(m_out));
            check("model sw_rise",    8'(sw_if.sw_rise),    8'(m_rise));
            check("model sw_fall",    8'(sw_if.sw_fall),    8'(m_fall));
            check("model any_change", 8'(sw_if.any_change), 8'(|(m_rise | m_fall)));
        end
    end

    // Downstream step counter driven by the debounced levels.
    logic [7:0] step_cnt;
    always @(posedge clk) begin
        if (rst) step_cnt <= '0;
        else if (sw_if.sw_out[SW_UPDN_BIT])
            step_cnt <= step_cnt + 8'(sw_if.sw_out[SW_STEP_MSB:SW_STEP_LSB]);
        else
            step_cnt <= step_cnt - 8'(sw_if.sw_out[SW_STEP_MSB:SW_STEP_LSB]);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] c0;

    initial begin
        sw_if.sw_in = 5'h0A;
        rst = 1'b1;
        // 1: reset
        cyc(2);
        check("rst sw_out", 8'(sw_if.sw_out), 8'h10);
        check("rst rise",   8'(sw_if.sw_rise), 8'h00);
        check("rst fall",   8'(sw_if.sw_fall), 8'h00);
        check("rst any",    8'(sw_if.any_change), 8'h00);
        rst = 1'b0;
        cyc(1);
        check("post-rst sw_out", 8'(sw_if.sw_out), 8'h10);
        sw_if.sw_in = 5'h10;
        cyc(8);
        check("short 0A ignored", 8'(sw_if.sw_out), 8'h10);

        // 2: 10 -> 13
        sw_if.sw_in = 5'h13;
        cyc(5);
        check("t2 before", 8'(sw_if.sw_out), 8'h10);
        cyc(1);
        check("t2 out",  8'(sw_if.sw_out), 8'h13);
        check("t2 rise", 8'(sw_if.sw_rise), 8'h03);
        check("t2 fall", 8'(sw_if.sw_fall), 8'h00);
        check("t2 any",  8'(sw_if.any_change), 8'h01);
        cyc(1);
        check("t2 rise end", 8'(sw_if.sw_rise), 8'h00);
        check("t2 any end",  8'(sw_if.any_change), 8'h00);

        // 3: glitch rejection on bit0, then a real rise
        sw_if.sw_in = 5'h12;
        cyc(8);
        check("t3 settle", 8'(sw_if.sw_out), 8'h12);
        sw_if.sw_in = 5'h13;
        cyc(3);
        sw_if.sw_in = 5'h12;
        cyc(8);
        check("t3 glitch", 8'(sw_if.sw_out), 8'h12);
        sw_if.sw_in = 5'h13;
        cyc(5);
        check("t3 before", 8'(sw_if.sw_out), 8'h12);
        cyc(1);
        check("t3 out",  8'(sw_if.sw_out), 8'h13);
        check("t3 rise", 8'(sw_if.sw_rise), 8'h01);

        // 4: up_down 1 -> 0
        cyc(4);
        sw_if.sw_in = 5'h03;
        cyc(6);
        check("t4 out",  8'(sw_if.sw_out), 8'h03);
        check("t4 fall", 8'(sw_if.sw_fall), 8'h10);
        check("t4 rise", 8'(sw_if.sw_rise), 8'h00);
        c0 = step_cnt;
        cyc(1);
        check("t4 count down", step_cnt, c0 - 8'd3);
        check("t4 fall end", 8'(sw_if.sw_fall), 8'h00);

        // 5: reset mid-count
        sw_if.sw_in = 5'h13;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("t5 rst out",  8'(sw_if.sw_out), 8'h10);
        check("t5 rst rise", 8'(sw_if.sw_rise), 8'h00);
        check("t5 rst fall", 8'(sw_if.sw_fall), 8'h00);
        cyc(5);
        check("t5 before", 8'(sw_if.sw_out), 8'h10);
        cyc(1);
        check("t5 out",  8'(sw_if.sw_out), 8'h13);
        check("t5 rise", 8'(sw_if.sw_rise), 8'h03);

        // 6: bits 0 and 3 one cycle apart
        cyc(4);
        sw_if.sw_in = 5'h12;
        cyc(1);
        sw_if.sw_in = 5'h1A;
        cyc(5);
        check("t6 fall0", 8'(sw_if.sw_fall), 8'h01);
        check("t6 rise0", 8'(sw_if.sw_rise), 8'h00);
        check("t6 any0",  8'(sw_if.any_change), 8'h01);
        cyc(1);
        check("t6 rise3", 8'(sw_if.sw_rise), 8'h08);
        check("t6 fall3", 8'(sw_if.sw_fall), 8'h00);
        check("t6 any3",  8'(sw_if.any_change), 8'h01);
        check("t6 out",   8'(sw_if.sw_out), 8'h1A);
        cyc(1);
        check("t6 any end", 8'(sw_if.any_change), 8'h00);
        cyc(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
